// File: rtl/sdrd_dirent_scanner.sv
// ---------------------------------------------------------------------------
// sdrd_dirent_scanner
//
// Producer side of the picture entry buffer. Parses the 32-bit word stream
// of FAT32 directory sectors as 32-byte directory entries (8 words each),
// keeps only regular picture files with extension EXT, and pushes each
// match's 28-bit start cluster into the picture entry FIFO.
//
// Ports:
//   CLK        clock
//   RST        synchronous active-high reset
//   START      one-cycle pulse: clear counters and begin a scan
//   DIR_END    one-cycle pulse: upstream cluster chain finished
//   IN_DATA    directory word, byte 4k in [7:0] .. byte 4k+3 in [31:24]
//   IN_VALID   IN_DATA valid
//   IN_READY   word accepted when IN_VALID & IN_READY
//   WR         buffer write strobe, one cycle per entry
//   OUTPUT     {4'b0, cluster[27:0]}, valid while WR=1, held otherwise
//   FULL       buffer full
//   PIC_COUNT  entries written in this scan
//   DONE       scan finished (level)
//   OVERFLOW   scan stopped because MAX_ENTRIES was reached
// ---------------------------------------------------------------------------
module sdrd_dirent_scanner #(
    parameter logic [23:0] EXT         = 24'h504D42,
    parameter int          MAX_ENTRIES = 128,
    parameter int          CNT_W       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             DIR_END,
    input  logic [31:0]      IN_DATA,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic             WR,
    output logic [31:0]      OUTPUT,
    input  logic             FULL,
    output logic [CNT_W-1:0] PIC_COUNT,
    output logic             DONE,
    output logic             OVERFLOW
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       word_idx, word_idx_nxt;
    logic [CNT_W-1:0] pic_count, pic_count_nxt, count_inc;
    logic             overflow_q, overflow_nxt;
    logic             dir_end_pend, dir_end_pend_nxt;

    // Latched fields of the entry currently being parsed
    logic [7:0]       byte0_q;
    logic [23:0]      ext_q;
    logic [7:0]       attr_q;
    logic [11:0]      cl_hi_q;
    logic [15:0]      cl_lo_q;
    logic [31:0]      out_q;

    logic             take;
    logic             in_ready_c;
    logic             wr_c;
    logic [27:0]      cluster;
    logic             entry_match;

    // Handshake: words are only taken while scanning, and an arriving
    // DIR_END wins over a word offered in the same cycle.
    assign in_ready_c = (state == ST_SCAN) && !DIR_END;
    assign take       = IN_VALID && in_ready_c;

    // The write happens combinationally in EMIT so that an entry completed
    // at cycle t is written at t+1 when the buffer has room.
    assign wr_c    = (state == ST_EMIT) && !FULL && !START;
    assign cluster = {cl_hi_q, cl_lo_q};

    // The size field arrives with word 7 itself, so it is tested directly
    // from IN_DATA in the same cycle the entry is evaluated.
    assign entry_match = (byte0_q != 8'hE5) &&
                         (attr_q != 8'h0F) &&
                         ((attr_q & 8'h18) == 8'h00) &&
                         (ext_q == EXT) &&
                         (IN_DATA != 32'd0) &&
                         (cluster >= 28'd2);

    assign count_inc = pic_count + CNT_W'(1);

    assign IN_READY  = in_ready_c;
    assign WR        = wr_c;
    assign OUTPUT    = wr_c ? {4'b0000, cluster} : out_q;
    assign PIC_COUNT = pic_count;
    assign DONE      = (state == ST_DONE);
    assign OVERFLOW  = overflow_q;

    // Next-state logic. START overrides everything; in EMIT the pending
    // write always completes before any stop condition is honoured.
    always_comb begin
        state_nxt        = state;
        word_idx_nxt     = word_idx;
        pic_count_nxt    = pic_count;
        overflow_nxt     = overflow_q;
        dir_end_pend_nxt = dir_end_pend;

        if (START) begin
            state_nxt        = ST_SCAN;
            word_idx_nxt     = 3'd0;
            pic_count_nxt    = '0;
            overflow_nxt     = 1'b0;
            dir_end_pend_nxt = 1'b0;
        end else begin
            case (state)
                ST_SCAN: begin
                    if (DIR_END) begin
                        state_nxt    = ST_DONE;
                        word_idx_nxt = 3'd0;
                    end else if (take) begin
                        if (word_idx == 3'd0 && IN_DATA[7:0] == 8'h00) begin
                            // End-of-directory marker
                            state_nxt    = ST_DONE;
                            word_idx_nxt = 3'd0;
                        end else begin
                            word_idx_nxt = word_idx + 3'd1;
                            if (word_idx == 3'd7 && entry_match) begin
                                state_nxt = ST_EMIT;
                            end
                        end
                    end
                end
                ST_EMIT: begin
                    if (DIR_END) begin
                        dir_end_pend_nxt = 1'b1;
                    end
                    if (!FULL) begin
                        pic_count_nxt    = count_inc;
                        dir_end_pend_nxt = 1'b0;
                        if (count_inc == MAX_CNT) begin
                            state_nxt    = ST_DONE;
                            overflow_nxt = 1'b1;
                        end else if (DIR_END || dir_end_pend) begin
                            state_nxt = ST_DONE;
                        end else begin
                            state_nxt = ST_SCAN;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, counters and the held OUTPUT value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= ST_IDLE;
            word_idx     <= 3'd0;
            pic_count    <= '0;
            overflow_q   <= 1'b0;
            dir_end_pend <= 1'b0;
            out_q        <= 32'd0;
        end else begin
            state        <= state_nxt;
            word_idx     <= word_idx_nxt;
            pic_count    <= pic_count_nxt;
            overflow_q   <= overflow_nxt;
            dir_end_pend <= dir_end_pend_nxt;
            if (wr_c) begin
                out_q <= {4'b0000, cluster};
            end
        end
    end

    // Field capture for the entry being parsed. Stale fields from a
    // discarded partial entry are harmless: every field is rewritten
    // before the next evaluation at word 7.
    always_ff @(posedge CLK) begin
        if (RST) begin
            byte0_q <= 8'd0;
            ext_q   <= 24'd0;
            attr_q  <= 8'd0;
            cl_hi_q <= 12'd0;
            cl_lo_q <= 16'd0;
        end else if (take && !START) begin
            case (word_idx)
                3'd0: byte0_q <= IN_DATA[7:0];
                3'd2: begin
                    ext_q  <= IN_DATA[23:0];
                    attr_q <= IN_DATA[31:24];
                end
                3'd5: cl_hi_q <= IN_DATA[11:0];
                3'd6: cl_lo_q <= IN_DATA[31:16];
                default: begin
                end
            endcase
        end
    end

endmodule
